cmp_int_bitserial: RTL and testbench

Multi-lane, bit-serial integer comparator for the compute array. Captures LANES operand pairs of WIDTH bits and evaluates them MSB-first, one bit per clock. Supports signed and unsigned operands and six relational ops, and returns a per-lane result bit through a valid/ready handshake. It generalises the existing combinational signed/unsigned greater-than submodules into a multi-op, multi-lane sequential unit that matches the array's bit-serial datapath.

---
 rtl/cmp_int_bitserial.sv | 124 ++++++++++++
 tb/tb_cmp_int_bitserial.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_int_bitserial.sv
// Multi-lane bit-serial comparator: EQ/NE/LT/LE/GT/GE, signed or unsigned, MSB-first.
// Optional macro CMP_BITSERIAL_EARLY_EXIT_EN ends RUN once every lane is decided.
module cmp_int_bitserial #(
   parameter int WIDTH = 32,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic               is_signed,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES-1:0]   y
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]             state;
   logic [IW-1:0]          idx;
   logic [LANES*WIDTH-1:0] a_q;
   logic [LANES*WIDTH-1:0] b_q;
   logic [2:0]             op_q;
   logic                   sgn_q;
   logic [LANES-1:0]       decided;
   logic [LANES-1:0]       gt;
   logic [LANES-1:0]       dec_nxt;
   logic [LANES-1:0]       gt_nxt;
   logic [WIDTH-1:0]       la;
   logic [WIDTH-1:0]       lb;
   logic                   msb;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign msb       = (idx == IW'(WIDTH - 1));

   // Evaluate the current bit for every undecided lane; the sign bit inverts the winner.
   always_comb begin
      dec_nxt = decided;
      gt_nxt  = gt;
      la      = '0;
      lb      = '0;
      for (int i = 0; i < LANES; i++) begin
         la = a_q[i*WIDTH +: WIDTH];
         lb = b_q[i*WIDTH +: WIDTH];
         if (!decided[i] && (la[idx] != lb[idx])) begin
            dec_nxt[i] = 1'b1;
            gt_nxt[i]  = (msb && sgn_q) ? lb[idx] : la[idx];
         end
      end
   end

   // Control FSM with operand capture and per-lane flag update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         decided <= '0;
         gt      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         sgn_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  sgn_q   <= is_signed;
                  decided <= '0;
                  gt      <= '0;
                  idx     <= IW'(WIDTH - 1);
                  state   <= RUN;
               end
            end
            RUN: begin
               decided <= dec_nxt;
               gt      <= gt_nxt;
               idx     <= idx - IW'(1);
               if (idx == '0) begin
                  state <= DONE;
`ifdef CMP_BITSERIAL_EARLY_EXIT_EN
               end else if (&dec_nxt) begin
                  state <= DONE;
`else
`endif
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Map latched flags to the requested relation; zero outside DONE.
   always_comb begin
      y = '0;
      if (state == DONE) begin
         for (int i = 0; i < LANES; i++) begin
            case (op_q)
               3'b000:  y[i] = ~decided[i];
               3'b001:  y[i] = decided[i];
               3'b010:  y[i] = decided[i] & ~gt[i];
               3'b011:  y[i] = ~decided[i] | ~gt[i];
               3'b100:  y[i] = decided[i] & gt[i];
               3'b101:  y[i] = ~(decided[i] & ~gt[i]);
               default: y[i] = 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmp_int_bitserial.sv
// Directed self-checking bench for cmp_int_bitserial.
// WIDTH=8, LANES=2; latency expectations follow CMP_BITSERIAL_EARLY_EXIT_EN.
module tb_cmp_int_bitserial;

   localparam int W = 8;
   localparam int L = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = 3'd0;
   logic          is_signed = 1'b0;
   logic [15:0]   a = '0;
   logic [15:0]   b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    y;

   int checks = 0;
   int errors = 0;

   cmp_int_bitserial #(.WIDTH(W), .LANES(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .is_signed(is_signed), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .y(y)
   );

   always #5 clk = ~clk;

   // Drive one command, wait for out_valid (bounded); lat=999 on timeout.
   task automatic run_cmd(input logic [2:0] o, input logic s,
                          input logic [15:0] aa, input logic [15:0] bb,
                          output int lat, output logic [1:0] yy);
      @(negedge clk);
      op = o; is_signed = s; a = aa; b = bb;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!out_valid) lat = 999;
      yy = y;
   endtask

   task automatic release_cmd();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (y !== 2'b00) begin
         errors++; $display("FAIL reset_y: got %b expected 00", y);
      end
   endtask

   task automatic test_signed_gt();
      int lat;
      logic [1:0] yy;
      int exp_lat;
`ifdef CMP_BITSERIAL_EARLY_EXIT_EN
      exp_lat = 3;
`else
      exp_lat = 8;
`endif
      run_cmd(3'b100, 1'b1, 16'h1080, 16'h207F, lat, yy);
      checks++;
      if (yy !== 2'b00) begin
         errors++; $display("FAIL signed_gt_y: got %b expected 00", yy);
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL signed_gt_lat: got %0d expected %0d", lat, exp_lat);
      end
      release_cmd();
      run_cmd(3'b100, 1'b0, 16'h1080, 16'h207F, lat, yy);
      checks++;
      if (yy !== 2'b01) begin
         errors++; $display("FAIL unsigned_gt_y: got %b expected 01", yy);
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL unsigned_gt_lat: got %0d expected %0d", lat, exp_lat);
      end
      release_cmd();
   endtask

   task automatic test_ties();
      logic [2:0] ops [7];
      logic [1:0] exp [7];
      int lat;
      logic [1:0] yy;
      ops[0] = 3'b000; exp[0] = 2'b11;
      ops[1] = 3'b001; exp[1] = 2'b00;
      ops[2] = 3'b011; exp[2] = 2'b11;
      ops[3] = 3'b101; exp[3] = 2'b11;
      ops[4] = 3'b010; exp[4] = 2'b00;
      ops[5] = 3'b100; exp[5] = 2'b00;
      ops[6] = 3'b111; exp[6] = 2'b00;
      for (int i = 0; i < 7; i++) begin
         run_cmd(ops[i], i[0], 16'h5A5A, 16'h5A5A, lat, yy);
         checks++;
         if (yy !== exp[i]) begin
            errors++;
            $display("FAIL tie_op%0b: got %b expected %b", ops[i], yy, exp[i]);
         end
         if (i == 0) begin
            checks++;
            if (lat != 8) begin
               errors++; $display("FAIL tie_lat: got %0d expected 8", lat);
            end
         end
         release_cmd();
      end
   endtask

   task automatic test_early_exit();
      int lat;
      logic [1:0] yy;
      int exp_lat;
`ifdef CMP_BITSERIAL_EARLY_EXIT_EN
      exp_lat = 1;
`else
      exp_lat = 8;
`endif
      run_cmd(3'b100, 1'b0, 16'h8080, 16'h0000, lat, yy);
      checks++;
      if (yy !== 2'b11) begin
         errors++; $display("FAIL early_y: got %b expected 11", yy);
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL early_lat: got %0d expected %0d", lat, exp_lat);
      end
      release_cmd();
      run_cmd(3'b100, 1'b0, 16'h3380, 16'h3300, lat, yy);
      checks++;
      if (yy !== 2'b01) begin
         errors++; $display("FAIL early_tie_y: got %b expected 01", yy);
      end
      checks++;
      if (lat != 8) begin
         errors++; $display("FAIL early_tie_lat: got %0d expected 8", lat);
      end
      release_cmd();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [1:0] yy;
      run_cmd(3'b010, 1'b0, 16'h0210, 16'h0120, lat, yy);
      checks++;
      if (yy !== 2'b01) begin
         errors++; $display("FAIL bp_y: got %b expected 01", yy);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = (c == 2);
         a = 16'hFFFF; b = 16'h0000; op = 3'b000;
         @(posedge clk);
         #1 in_valid = 1'b0;
         checks++;
         if (y !== 2'b01) begin
            errors++; $display("FAIL bp_hold_y%0d: got %b expected 01", c, y);
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", c, out_valid);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", c, in_ready);
         end
      end
      release_cmd();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_no_ghost: got in_ready %b expected 1", in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      logic [1:0] yy;
      @(negedge clk);
      op = 3'b000; is_signed = 1'b0; a = 16'h1234; b = 16'h1234;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_run_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_run_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (y !== 2'b00) begin
         errors++; $display("FAIL rst_run_y: got %b expected 00", y);
      end
      run_cmd(3'b010, 1'b1, 16'h01FF, 16'hFF01, lat, yy);
      checks++;
      if (yy !== 2'b01) begin
         errors++; $display("FAIL rst_then_lt: got %b expected 01", yy);
      end
      release_cmd();
   endtask

   task automatic test_input_stability();
      int lat;
      @(negedge clk);
      op = 3'b010; is_signed = 1'b1; a = 16'h10F0; b = 16'h200F;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         op = 3'($urandom_range(0, 7));
         is_signed = 1'($urandom_range(0, 1));
         a = 16'($urandom);
         b = 16'($urandom);
         @(posedge clk);
         #1 lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL stab_timeout: out_valid %b expected 1", out_valid);
      end
      checks++;
      if (y !== 2'b11) begin
         errors++; $display("FAIL stab_y: got %b expected 11", y);
      end
      release_cmd();
   endtask

   initial begin
      test_reset();
      test_signed_gt();
      test_ties();
      test_early_exit();
      test_backpressure();
      test_reset_mid_run();
      test_input_stability();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
